// File: rtl/cpu_ctrl_pkg.sv
// Shared types and field helpers for the CPU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_MEM_RD, S_ALU_IN, S_EXEC,
    S_ALU_OUT, S_MEM_WR, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_ST  = 2'b01;
  localparam logic [1:0] MODE_LD  = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  // Command word layout, LSB first: op, sel_a, sel_b, mode.
  function automatic int sela_lsb(input int op_w);
    return op_w;
  endfunction

  function automatic int selb_lsb(input int op_w, input int sel_w);
    return op_w + sel_w;
  endfunction

  function automatic int mode_lsb(input int op_w, input int sel_w);
    return op_w + 2 * sel_w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_lat_counter.sv
// Loadable down-counter; zero flags the last cycle of a timed state.
module ctrl_lat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer driving the small CPU datapath enables.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int SEL_W    = 2,
  parameter int NUM_OPS  = 10,
  parameter int ALU_LAT  = 1,
  parameter int MEM_LAT  = 2,
  parameter int ERRCNT_W = 8,
  localparam int CMD_W   = OP_W + 2 * SEL_W + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CMD_W-1:0]    cmd_in,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                p_error,
  output logic                datain_reg_en,
  output logic                aluin_reg_en,
  output logic                aluout_reg_en,
  output logic                memoryRead,
  output logic                memoryWrite,
  output logic                selmux2,
  output logic [SEL_W-1:0]    in_select_a,
  output logic [SEL_W-1:0]    in_select_b,
  output logic [OP_W-1:0]     opcode,
  output logic                invalid_data,
  output logic                busy,
  output logic                done,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int SA_LSB = sela_lsb(OP_W);
  localparam int SB_LSB = selb_lsb(OP_W, SEL_W);
  localparam int MD_LSB = mode_lsb(OP_W, SEL_W);
  localparam int CNT_W  = $clog2(max2(ALU_LAT, MEM_LAT)) + 1;

  state_t           state, state_n;
  logic [CMD_W-1:0] cmd_q;
  logic [1:0]       mode_q, mode_in;
  logic             cmd_bad;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  assign mode_q  = cmd_q[MD_LSB +: 2];
  assign mode_in = cmd_in[MD_LSB +: 2];
  assign cmd_bad = (32'(cmd_in[OP_W-1:0]) >= NUM_OPS) || (mode_in == MODE_BAD);
  assign cmd_ready = (state == S_IDLE) && !rst;

  // State, latched command and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cmd_q   <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && cmd_valid) cmd_q <= cmd_in;
      if (state == S_ERR && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Next-state logic; timed states exit on the counter's zero flag.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (cmd_valid) state_n = cmd_bad ? S_ERR : S_LATCH;
      S_LATCH:   state_n = (mode_q == MODE_LD) ? S_MEM_RD : S_ALU_IN;
      S_MEM_RD:  if (cnt_zero) state_n = S_ALU_IN;
      S_ALU_IN:  state_n = S_EXEC;
      S_EXEC:    if (cnt_zero) state_n = S_ALU_OUT;
      S_ALU_OUT: state_n = p_error ? S_ERR : (mode_q == MODE_ST) ? S_MEM_WR : S_DONE;
      S_MEM_WR:  if (cnt_zero) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      S_ERR:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Reload the latency counter on every state change; only timed states read it.
  always_comb begin
    cnt_load = (state_n != state);
    cnt_val  = (state_n == S_EXEC) ? CNT_W'(ALU_LAT - 1) : CNT_W'(MEM_LAT - 1);
  end

  ctrl_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  // Moore output decode from registered state and latched command.
  always_comb begin
    datain_reg_en = 1'b0;
    aluin_reg_en  = 1'b0;
    aluout_reg_en = 1'b0;
    memoryRead    = 1'b0;
    memoryWrite   = 1'b0;
    selmux2       = 1'b0;
    in_select_a   = '0;
    in_select_b   = '0;
    opcode        = '0;
    invalid_data  = 1'b0;
    done          = 1'b0;
    busy          = (state != S_IDLE);
    unique case (state)
      S_LATCH:   datain_reg_en = 1'b1;
      S_MEM_RD:  memoryRead = 1'b1;
      S_ALU_IN: begin
        aluin_reg_en = 1'b1;
        in_select_a  = cmd_q[SA_LSB +: SEL_W];
        in_select_b  = cmd_q[SB_LSB +: SEL_W];
        opcode       = cmd_q[OP_W-1:0];
      end
      S_EXEC:    opcode = cmd_q[OP_W-1:0];
      S_ALU_OUT: begin
        aluout_reg_en = 1'b1;
        opcode        = cmd_q[OP_W-1:0];
      end
      S_MEM_WR: begin
        memoryWrite = 1'b1;
        selmux2     = 1'b1;
      end
      S_DONE:    done = 1'b1;
      S_ERR: begin
        invalid_data = 1'b1;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench: per-cycle expected output vectors are queued per command.
module tb_cpu_ctrl_seq;

  localparam int ALU_LAT = 1;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cmd_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        p_error;
  logic        datain_reg_en, aluin_reg_en, aluout_reg_en;
  logic        memoryRead, memoryWrite, selmux2;
  logic [1:0]  in_select_a, in_select_b;
  logic [3:0]  opcode;
  logic        invalid_data, busy, done;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(
    .OP_W(4), .SEL_W(2), .NUM_OPS(10), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .ERRCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .p_error(p_error), .datain_reg_en(datain_reg_en), .aluin_reg_en(aluin_reg_en),
    .aluout_reg_en(aluout_reg_en), .memoryRead(memoryRead), .memoryWrite(memoryWrite),
    .selmux2(selmux2), .in_select_a(in_select_a), .in_select_b(in_select_b),
    .opcode(opcode), .invalid_data(invalid_data), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  assign obs = {datain_reg_en, aluin_reg_en, aluout_reg_en, memoryRead, memoryWrite, selmux2,
                in_select_a, in_select_b, opcode, invalid_data, busy, done, cmd_ready};

  function automatic logic [17:0] ov(input bit di, ai, ao, mr, mw, sm,
                                     input logic [1:0] sa, sb, input logic [3:0] op,
                                     input bit inv, bsy, dn, rdy);
    return {di, ai, ao, mr, mw, sm, sa, sb, op, inv, bsy, dn, rdy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one command from IDLE, check every cycle until back in IDLE.
  // abort_at >= 0: assert rst after that cycle index and expect an idle DUT.
  task automatic run_cmd(input string name, input logic [1:0] mode, input logic [3:0] op,
                         input logic [1:0] sa, input logic [1:0] sb, input bit perr,
                         input int abort_at);
    bit bad;
    int ao_idx;
    int n;
    bad = (op >= 4'd10) || (mode == 2'b11);
    ao_idx = -1;
    if (bad) begin
      exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,4'd0,1,1,1,0));
    end else begin
      exp_q.push_back(ov(1,0,0,0,0,0,2'd0,2'd0,4'd0,0,1,0,0));
      if (mode == 2'b10)
        repeat (MEM_LAT) exp_q.push_back(ov(0,0,0,1,0,0,2'd0,2'd0,4'd0,0,1,0,0));
      exp_q.push_back(ov(0,1,0,0,0,0,sa,sb,op,0,1,0,0));
      repeat (ALU_LAT) exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,op,0,1,0,0));
      ao_idx = exp_q.size();
      exp_q.push_back(ov(0,0,1,0,0,0,2'd0,2'd0,op,0,1,0,0));
      if (perr) begin
        exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,4'd0,1,1,1,0));
      end else begin
        if (mode == 2'b01)
          repeat (MEM_LAT) exp_q.push_back(ov(0,0,0,0,1,1,2'd0,2'd0,4'd0,0,1,0,0));
        exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,4'd0,0,1,1,0));
      end
    end
    exp_q.push_back(ov(0,0,0,0,0,0,2'd0,2'd0,4'd0,0,0,0,1));

    cmd_in = {mode, sb, sa, op};
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0) begin
      // p_error is held high outside ALU_OUT: it must be ignored there.
      p_error = (n == ao_idx) ? perr : 1'b1;
      #1;
      chk($sformatf("%s c%0d", name, n + 1), 32'(obs), 32'(exp_q.pop_front()));
      if (n == abort_at) begin
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
          #1;
          chk($sformatf("%s abort idle", name), 32'(obs), 32'(ov(0,0,0,0,0,0,2'd0,2'd0,4'd0,0,0,0,1)));
          @(posedge clk); #1;
        end
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    p_error = 1'b0;
    if (abort_at < 0 && (bad || perr)) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    if (abort_at >= 0) exp_err = 0;
    chk($sformatf("%s err_cnt", name), 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_in = {2'b00, 2'd2, 2'd1, 4'd0};
    p_error = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst outputs", 32'(obs), 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("post-rst ready", 32'(obs), 32'(ov(0,0,0,0,0,0,2'd0,2'd0,4'd0,0,0,0,1)));

    run_cmd("alu",       2'b00, 4'd0,  2'd1, 2'd2, 1'b0, -1);
    run_cmd("alu_st",    2'b01, 4'd3,  2'd3, 2'd0, 1'b0, -1);
    run_cmd("ld_alu",    2'b10, 4'd5,  2'd2, 2'd3, 1'b0, -1);
    run_cmd("st_perr",   2'b01, 4'd7,  2'd2, 2'd1, 1'b1, -1);
    run_cmd("bad_op",    2'b00, 4'd12, 2'd1, 2'd1, 1'b0, -1);
    run_cmd("bad_mode",  2'b11, 4'd2,  2'd0, 2'd1, 1'b0, -1);
    run_cmd("op_max",    2'b00, 4'd9,  2'd3, 2'd3, 1'b0, -1);
    run_cmd("op_ten",    2'b10, 4'd10, 2'd0, 2'd0, 1'b0, -1);
    run_cmd("ld_perr",   2'b10, 4'd1,  2'd1, 2'd0, 1'b1, -1);
    run_cmd("st_abort",  2'b01, 4'd4,  2'd1, 2'd3, 1'b0, 2);
    run_cmd("alu_after", 2'b00, 4'd6,  2'd2, 2'd1, 1'b0, -1);
    run_cmd("st_after",  2'b01, 4'd8,  2'd0, 2'd2, 1'b0, -1);
    while (exp_err < 255) run_cmd("fill", 2'b11, 4'd0, 2'd0, 2'd0, 1'b0, -1);
    run_cmd("sat", 2'b00, 4'd15, 2'd0, 2'd0, 1'b0, -1);
    chk("sat hold", 32'(err_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
